// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR memory access sequencer.
// Moore FSM with a ready/timeout handshake toward memory.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clock,
    input  logic clear,
    input  logic req,
    input  logic rw,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic error,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic mem_rd,
    output logic mem_wr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_RD_LATCH,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 rw_q;
    logic                 rw_d;
    logic                 timeout;

    assign timeout = (cnt == CNT_LAST);

    // State, wait counter and latched access type
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rw_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rw_q  <= rw_d;
        end
    end

    // Next state, counter update and Moore output decode
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rw_d    = rw_q;
        busy    = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        Read    = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                busy    = 1'b1;
                MARin   = 1'b1;
                cnt_d   = '0;
                state_d = rw_q ? ST_DATA : ST_RD_WAIT;
            end
            ST_DATA: begin
                busy    = 1'b1;
                MDRin   = 1'b1;
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                busy   = 1'b1;
                mem_wr = 1'b1;
                // ready beats a timeout landing on the same cycle
                if (mem_ready) begin
                    state_d = ST_DONE;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RD_WAIT: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                Read   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_RD_LATCH;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RD_LATCH: begin
                busy    = 1'b1;
                MDRin   = 1'b1;
                Read    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                busy    = 1'b1;
                error   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed bench
// with a per-access expected-output schedule model.
module tb_mem_access_ctrl;

    localparam int T = 16;

    typedef logic [7:0] ov_t;
    localparam ov_t O_BUSY = 8'h80;
    localparam ov_t O_DONE = 8'h40;
    localparam ov_t O_ERR  = 8'h20;
    localparam ov_t O_MAR  = 8'h10;
    localparam ov_t O_MDR  = 8'h08;
    localparam ov_t O_READ = 8'h04;
    localparam ov_t O_RD   = 8'h02;
    localparam ov_t O_WR   = 8'h01;

    logic clock = 1'b0;
    logic clear;
    logic req;
    logic rw;
    logic mem_ready;
    logic busy, done, error, MARin, MDRin, Read, mem_rd, mem_wr;

    logic [31:0] bus;
    logic [31:0] mdatain;
    logic [31:0] mdr;

    ov_t act;
    ov_t exp_v;
    ov_t exp_q[$];
    ov_t obs[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .clear(clear),
        .req(req),
        .rw(rw),
        .mem_ready(mem_ready),
        .busy(busy),
        .done(done),
        .error(error),
        .MARin(MARin),
        .MDRin(MDRin),
        .Read(Read),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr)
    );

    assign act = {busy, done, error, MARin, MDRin, Read, mem_rd, mem_wr};

    // Small MDR stand-in driven by the sequencer strobes
    always_ff @(posedge clock or posedge clear) begin
        if (clear) mdr <= '0;
        else if (MDRin) mdr <= Read ? mdatain : bus;
    end

    // Compare process: one expected vector per scheduled cycle
    always @(negedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            obs.push_back(act);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d: outputs=%b required=%b",
                         obs.size() - 1, act, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    function automatic int cnt_mask(input int base, input ov_t m);
        int n = 0;
        for (int i = base; i < obs.size(); i++)
            if ((obs[i] & m) != 0) n++;
        return n;
    endfunction

    function automatic int first_idx(input int base, input int nth,
                                     input ov_t m);
        int n = 0;
        for (int i = base; i < obs.size(); i++) begin
            if ((obs[i] & m) != 0) begin
                if (n == nth) return i - base;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic logic rnd();
        return logic'($urandom() % 2);
    endfunction

    // mode: 0 random req while busy, 1 req held high, 2 held low
    function automatic logic rq_of(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return rnd();
    endfunction

    task automatic step(input logic rq, input logic r,
                        input logic rdy, input ov_t e);
        @(negedge clock);
        req       = rq;
        rw        = r;
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    // One access: w = mem_ready-low cycles in the wait state;
    // w >= T means memory never answers.
    task automatic access(input logic r, input int w,
                          input int gap, input int mode);
        int   n;
        ov_t  wv;
        logic ok;
        ok = (w < T);
        n  = ok ? w : T;
        wv = r ? (O_BUSY | O_WR) : (O_BUSY | O_RD | O_READ);
        for (int i = 0; i < gap; i++) step(1'b0, rnd(), rnd(), 8'h00);
        step(1'b1, r, rnd(), 8'h00);
        step(rq_of(mode), rnd(), rnd(), O_BUSY | O_MAR);
        if (r) step(rq_of(mode), rnd(), rnd(), O_BUSY | O_MDR);
        for (int i = 0; i < n; i++) step(rq_of(mode), rnd(), 1'b0, wv);
        if (ok) step(rq_of(mode), rnd(), 1'b1, wv);
        if (!r && ok)
            step(rq_of(mode), rnd(), rnd(), O_BUSY | O_MDR | O_READ);
        step(rq_of(mode), rnd(), rnd(), ok ? (O_BUSY | O_DONE)
                                           : (O_BUSY | O_ERR));
    endtask

    initial begin
        int base;
        int d;
        clear     = 1'b1;
        req       = 1'b0;
        rw        = 1'b0;
        mem_ready = 1'b0;
        bus       = 32'h0000_00A5;
        mdatain   = 32'hDEAD_BEEF;
        repeat (2) @(negedge clock);
        #2;
        chk("reset_outputs", 32'(act), 32'h0);
        @(negedge clock);
        clear = 1'b0;

        // Load, zero wait states
        base = obs.size();
        access(1'b0, 0, 0, 2);
        #2;
        chk("load_marin_cycle", first_idx(base, 0, O_MAR), 1);
        chk("load_rd_cycle", first_idx(base, 0, O_RD), 2);
        chk("load_done_cycle", first_idx(base, 0, O_DONE), 4);
        chk("load_mdr", mdr, 32'hDEAD_BEEF);

        // Store, 3 wait states
        base = obs.size();
        access(1'b1, 3, 1, 2);
        #2;
        chk("store_wr_cycles", cnt_mask(base, O_WR), 4);
        chk("store_done_cycle", first_idx(base, 0, O_DONE), 8);
        chk("store_mdr", mdr, 32'h0000_00A5);

        // Timeout: memory never answers
        base = obs.size();
        access(1'b0, T, 0, 0);
        #2;
        chk("timeout_rd_cycles", cnt_mask(base, O_RD), 16);
        chk("timeout_err_count", cnt_mask(base, O_ERR), 1);
        chk("timeout_done_count", cnt_mask(base, O_DONE), 0);

        // Boundary: ready on the timeout cycle
        base = obs.size();
        access(1'b0, T - 1, 0, 0);
        #2;
        chk("boundary_err_count", cnt_mask(base, O_ERR), 0);
        chk("boundary_done_cycle", first_idx(base, 0, O_DONE), 19);

        // Back-to-back with req held high
        base = obs.size();
        access(1'b0, 0, 0, 1);
        access(1'b1, 0, 0, 1);
        #2;
        chk("b2b_marin_count", cnt_mask(base, O_MAR), 2);
        chk("b2b_second_marin", first_idx(base, 1, O_MAR), 6);
        chk("b2b_done_count", cnt_mask(base, O_DONE), 2);

        // Asynchronous clear in the middle of RD_WAIT
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, O_BUSY | O_MAR);
        step(1'b0, 1'b0, 1'b0, O_BUSY | O_RD | O_READ);
        step(1'b0, 1'b0, 1'b0, O_BUSY | O_RD | O_READ);
        #3;
        chk("pre_clear_mem_rd", 32'(mem_rd), 32'h1);
        clear = 1'b1;
        #1;
        chk("async_clear_outputs", 32'(act), 32'h0);
        @(negedge clock);
        clear = 1'b0;
        req   = 1'b0;
        base  = obs.size();
        access(1'b0, 1, 0, 2);
        #2;
        chk("post_clear_done_cycle", first_idx(base, 0, O_DONE), 5);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            d = ($urandom() % 4 == 0) ? $urandom_range(T - 2, T + 2)
                                      : $urandom_range(0, 4);
            bus     = $urandom();
            mdatain = $urandom();
            access(rnd(), d, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        #3;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
